// File: rtl/i2c_master_burst.sv
// rtl/i2c_master_burst.sv - I2C burst master: register writes and repeated-START register reads
//
// Purpose:
//   Runs one I2C register transaction per command: START, 7-bit slave address,
//   register address, then either 1..MAX_BYTES write bytes or a repeated START
//   followed by 1..MAX_BYTES read bytes, then STOP. One clk period is one SCL bit.
//   SCL is held low while the local side has not supplied or accepted a byte.
//
// Ports:
//   i_clk, i_reset                 bit-rate clock, synchronous active-high reset
//   o_i2c_scl, io_i2c_sda          bus pins (SDA open-drain: drives 0 or releases)
//   i_cmd_valid / o_cmd_ready      command handshake (ready only in IDLE)
//   i_slav_addr, i_read_not_write,
//   i_reg_addr, i_byte_count       command fields, captured on the handshake
//   i_write_data, i_write_valid / o_write_ready   write byte stream
//   o_read_data, o_read_valid / i_read_ready      read byte stream
//   o_busy                         high whenever not IDLE
//   o_error                        sticky NACK flag, cleared by the next command

module i2c_master_burst #(
    parameter int MAX_BYTES = 4,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    output logic             o_i2c_scl,
    inout  wire              io_i2c_sda,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [6:0]       i_slav_addr,
    input  logic             i_read_not_write,
    input  logic [7:0]       i_reg_addr,
    input  logic [LEN_W-1:0] i_byte_count,
    input  logic [7:0]       i_write_data,
    input  logic             i_write_valid,
    output logic             o_write_ready,
    output logic [7:0]       o_read_data,
    output logic             o_read_valid,
    input  logic             i_read_ready,
    output logic             o_busy,
    output logic             o_error
);

    localparam logic [4:0] S_IDLE    = 5'd0;
    localparam logic [4:0] S_START   = 5'd1;
    localparam logic [4:0] S_ADDR    = 5'd2;
    localparam logic [4:0] S_RW      = 5'd3;
    localparam logic [4:0] S_ACK_A   = 5'd4;
    localparam logic [4:0] S_REG     = 5'd5;
    localparam logic [4:0] S_ACK_R   = 5'd6;
    localparam logic [4:0] S_WR_WAIT = 5'd7;
    localparam logic [4:0] S_WR_DATA = 5'd8;
    localparam logic [4:0] S_ACK_W   = 5'd9;
    localparam logic [4:0] S_RS0     = 5'd10;
    localparam logic [4:0] S_RS1     = 5'd11;
    localparam logic [4:0] S_RS2     = 5'd12;
    localparam logic [4:0] S_ADDR2   = 5'd13;
    localparam logic [4:0] S_RW2     = 5'd14;
    localparam logic [4:0] S_ACK_A2  = 5'd15;
    localparam logic [4:0] S_RD_DATA = 5'd16;
    localparam logic [4:0] S_RD_WAIT = 5'd17;
    localparam logic [4:0] S_MACK    = 5'd18;
    localparam logic [4:0] S_STOP0   = 5'd19;
    localparam logic [4:0] S_STOP1   = 5'd20;
    localparam logic [4:0] S_STOP2   = 5'd21;

    logic [4:0]       r_state;
    logic [2:0]       r_bit_cnt;
    logic [6:0]       r_addr;
    logic             r_rnw;
    logic [7:0]       r_reg;
    logic [LEN_W-1:0] r_count;
    logic [7:0]       r_wbyte;
    logic [6:0]       r_shift;
    logic [7:0]       r_read_data;
    logic             r_error;

    logic [LEN_W-1:0] w_count_load;
    logic             w_sda_in;
    logic             w_sda_low;
    logic             w_scl_hold_low;
    logic             w_scl_idle;

    // Out-of-range lengths are clamped at capture so the counter can never wrap.
    always_comb begin
        w_count_load = i_byte_count;
        if (i_byte_count == '0) begin
            w_count_load = LEN_W'(1);
        end else if (i_byte_count > LEN_W'(MAX_BYTES)) begin
            w_count_load = LEN_W'(MAX_BYTES);
        end
    end

    // Released bus reads as 1, so a 1 in an ACK slot is a NACK.
    assign w_sda_in = io_i2c_sda;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_addr      <= '0;
            r_rnw       <= 1'b0;
            r_reg       <= '0;
            r_count     <= '0;
            r_wbyte     <= '0;
            r_shift     <= '0;
            r_read_data <= '0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_addr    <= i_slav_addr;
                        r_rnw     <= i_read_not_write;
                        r_reg     <= i_reg_addr;
                        r_count   <= w_count_load;
                        r_error   <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= S_START;
                    end
                end
                S_START: r_state <= S_ADDR;
                S_ADDR: begin
                    if (r_bit_cnt == 3'd6) begin
                        r_bit_cnt <= '0;
                        r_state   <= S_RW;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end
                S_RW: r_state <= S_ACK_A;
                S_ACK_A: begin
                    if (w_sda_in) begin
                        r_error <= 1'b1;
                        r_state <= S_STOP0;
                    end else begin
                        r_state <= S_REG;
                    end
                end
                S_REG: begin
                    if (r_bit_cnt == 3'd7) begin
                        r_bit_cnt <= '0;
                        r_state   <= S_ACK_R;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end
                S_ACK_R: begin
                    if (w_sda_in) begin
                        r_error <= 1'b1;
                        r_state <= S_STOP0;
                    end else if (r_rnw) begin
                        r_state <= S_RS0;
                    end else begin
                        r_state <= S_WR_WAIT;
                    end
                end
                S_WR_WAIT: begin
                    if (i_write_valid) begin
                        r_wbyte <= i_write_data;
                        r_state <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (r_bit_cnt == 3'd7) begin
                        r_bit_cnt <= '0;
                        r_count   <= r_count - LEN_W'(1);
                        r_state   <= S_ACK_W;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end
                S_ACK_W: begin
                    if (w_sda_in) begin
                        r_error <= 1'b1;
                        r_state <= S_STOP0;
                    end else if (r_count != '0) begin
                        r_state <= S_WR_WAIT;
                    end else begin
                        r_state <= S_STOP0;
                    end
                end
                S_RS0: r_state <= S_RS1;
                S_RS1: r_state <= S_RS2;
                S_RS2: r_state <= S_ADDR2;
                S_ADDR2: begin
                    if (r_bit_cnt == 3'd6) begin
                        r_bit_cnt <= '0;
                        r_state   <= S_RW2;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end
                S_RW2: r_state <= S_ACK_A2;
                S_ACK_A2: begin
                    if (w_sda_in) begin
                        r_error <= 1'b1;
                        r_state <= S_STOP0;
                    end else begin
                        r_state <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    r_shift <= {r_shift[5:0], w_sda_in};
                    if (r_bit_cnt == 3'd7) begin
                        r_read_data <= {r_shift, w_sda_in};
                        r_bit_cnt   <= '0;
                        r_count     <= r_count - LEN_W'(1);
                        r_state     <= S_RD_WAIT;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end
                S_RD_WAIT: begin
                    if (i_read_ready) begin
                        r_state <= S_MACK;
                    end
                end
                S_MACK: begin
                    if (r_count != '0) begin
                        r_state <= S_RD_DATA;
                    end else begin
                        r_state <= S_STOP0;
                    end
                end
                S_STOP0: r_state <= S_STOP1;
                S_STOP1: r_state <= S_STOP2;
                S_STOP2: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // SDA is a pure function of registered state, so it only moves on posedge clk
    // while SCL is in its low half.
    always_comb begin
        w_sda_low = 1'b0;
        case (r_state)
            S_START, S_RW, S_WR_WAIT, S_RS2, S_STOP0, S_STOP1: w_sda_low = 1'b1;
            S_ADDR, S_ADDR2: w_sda_low = ~r_addr[3'd6 - r_bit_cnt];
            S_REG:           w_sda_low = ~r_reg[3'd7 - r_bit_cnt];
            S_WR_DATA:       w_sda_low = ~r_wbyte[3'd7 - r_bit_cnt];
            // ACK while more bytes are wanted, NACK on the last one.
            S_MACK:          w_sda_low = (r_count != '0);
            default:         w_sda_low = 1'b0;
        endcase
    end

    assign io_i2c_sda = w_sda_low ? 1'b0 : 1'bz;

    // Stretch states keep SCL low; START/STOP/repeated-START framing keeps it high;
    // every other state gives one SCL pulse in the second half of the clk period.
    assign w_scl_hold_low = (r_state == S_WR_WAIT) || (r_state == S_RD_WAIT) ||
                            (r_state == S_RS0);
    assign w_scl_idle     = (r_state == S_IDLE)  || (r_state == S_START) ||
                            (r_state == S_RS1)   || (r_state == S_RS2)   ||
                            (r_state == S_STOP1) || (r_state == S_STOP2);
    assign o_i2c_scl      = w_scl_hold_low ? 1'b0 : (w_scl_idle | ~i_clk);

    assign o_cmd_ready   = (r_state == S_IDLE);
    assign o_busy        = (r_state != S_IDLE);
    assign o_write_ready = (r_state == S_WR_WAIT);
    assign o_read_valid  = (r_state == S_RD_WAIT);
    assign o_read_data   = r_read_data;
    assign o_error       = r_error;

endmodule
